regbank_access_arb: RTL and testbench

Two-requester arbiter and access sequencer for a bank of software-accessible register slices. It shares the single software write/read path of a register bank between a primary bus port (requester 0) and a debug port (requester 1). It turns each granted transaction into a one-cycle write-enable or read-pulse on exactly one register slice, then returns read data or an error to the winning requester. It sits between the bus adapters and the register bank's per-register `we`/`wd`/`qs` connections.

---
 rtl/regbank_access_arb.sv | 165 ++++++++++++++++
 tb/tb_regbank_access_arb.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/regbank_access_arb.sv
// regbank_access_arb: round-robin arbiter between a bus port (requester 0)
// and a debug port (requester 1). It turns each granted access into a
// one-cycle write or read pulse on one register slice, then returns a
// response to the winner. Each access takes three cycles: IDLE -> ACCESS -> RESP.
module regbank_access_arb #(
  parameter int unsigned     NREG    = 8,
  parameter int unsigned     DW      = 32,
  parameter int unsigned     AW      = 3,
  parameter logic [NREG-1:0] RO_MASK = '0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [1:0]        req_i,
  input  logic [1:0]        we_i,
  input  logic [2*AW-1:0]   addr_i,
  input  logic [2*DW-1:0]   wdata_i,
  output logic [1:0]        gnt_o,
  output logic [1:0]        rvalid_o,
  output logic [DW-1:0]     rdata_o,
  output logic              err_o,
  output logic [NREG-1:0]   reg_we_o,
  output logic [NREG-1:0]   reg_re_o,
  output logic [DW-1:0]     reg_wd_o,
  input  logic [NREG*DW-1:0] reg_qs_i
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e            state_q, state_d;
  logic              prio_q;
  logic              win_q;
  logic              we_q;
  logic              err_q;
  logic [NREG-1:0]   sel_q;

  logic [NREG-1:0]   reg_we_q, reg_re_q;
  logic [DW-1:0]     reg_wd_q;
  logic [1:0]        rvalid_q;
  logic [DW-1:0]     rdata_q;
  logic              rsp_err_q;

  // Candidate transaction of the requester that would win this cycle.
  logic              win_d;
  logic              cand_we;
  logic [AW-1:0]     cand_addr;
  logic [DW-1:0]     cand_wdata;
  logic [NREG-1:0]   cand_sel;
  logic              cand_err;
  logic [DW-1:0]     qs_sel;

  // Round-robin pick: a lone requester always wins, otherwise prio wins.
  always_comb begin
    win_d = prio_q;
    if (req_i == 2'b01) begin
      win_d = 1'b0;
    end else if (req_i == 2'b10) begin
      win_d = 1'b1;
    end
  end

  assign cand_we    = win_d ? we_i[1] : we_i[0];
  assign cand_addr  = win_d ? addr_i[2*AW-1:AW] : addr_i[AW-1:0];
  assign cand_wdata = win_d ? wdata_i[2*DW-1:DW] : wdata_i[DW-1:0];

  // One-hot slice decode; an unmapped address decodes to all zeros.
  for (genvar gi = 0; gi < NREG; gi++) begin : g_dec
    assign cand_sel[gi] = (32'(cand_addr) == 32'(gi));
  end

  assign cand_err = ~(|cand_sel) | (cand_we & |(cand_sel & RO_MASK));

  // Read-back mux over the slice values, selected by the latched decode.
  always_comb begin
    qs_sel = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      if (sel_q[i]) begin
        qs_sel = qs_sel | reg_qs_i[i*DW +: DW];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state and the combinational grant.
  always_comb begin
    state_d = state_q;
    gnt_o   = 2'b00;
    case (state_q)
      IDLE: begin
        if (|req_i) begin
          gnt_o   = win_d ? 2'b10 : 2'b01;
          state_d = ACCESS;
        end
      end
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Transaction latch, register pulses and response registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio_q    <= 1'b0;
      win_q     <= 1'b0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      sel_q     <= '0;
      reg_we_q  <= '0;
      reg_re_q  <= '0;
      reg_wd_q  <= '0;
      rvalid_q  <= 2'b00;
      rdata_q   <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      reg_we_q  <= '0;
      reg_re_q  <= '0;
      reg_wd_q  <= '0;
      rvalid_q  <= 2'b00;
      rdata_q   <= '0;
      rsp_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|req_i) begin
            win_q  <= win_d;
            we_q   <= cand_we;
            err_q  <= cand_err;
            sel_q  <= cand_sel;
            prio_q <= ~win_d;
            if (!cand_err) begin
              if (cand_we) begin
                reg_we_q <= cand_sel;
                reg_wd_q <= cand_wdata;
              end else begin
                reg_re_q <= cand_sel;
              end
            end
          end
        end
        ACCESS: begin
          // Slice value sampled before its own update (read-to-clear safe).
          rvalid_q  <= win_q ? 2'b10 : 2'b01;
          rsp_err_q <= err_q;
          rdata_q   <= (!we_q && !err_q) ? qs_sel : '0;
        end
        default: ;
      endcase
    end
  end

  assign reg_we_o = reg_we_q;
  assign reg_re_o = reg_re_q;
  assign reg_wd_o = reg_wd_q;
  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign err_o    = rsp_err_q;

endmodule

// File: tb/tb_regbank_access_arb.sv
// Testbench for regbank_access_arb: directed scenarios plus random traffic,
// checked against a transaction-level model of arbitration and register contents.
module tb_regbank_access_arb;

  localparam int unsigned NREG = 6;
  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = 3;
  localparam logic [NREG-1:0] RO = 6'b000010;
  localparam int unsigned RC_REG = 5;  // read-to-clear slice in the bank model

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic [1:0]        req_i, we_i;
  logic [2*AW-1:0]   addr_i;
  logic [2*DW-1:0]   wdata_i;
  logic [1:0]        gnt_o, rvalid_o;
  logic [DW-1:0]     rdata_o;
  logic              err_o;
  logic [NREG-1:0]   reg_we_o, reg_re_o;
  logic [DW-1:0]     reg_wd_o;
  logic [NREG*DW-1:0] reg_qs_i;

  int n_chk  = 0;
  int n_fail = 0;

  logic [DW-1:0] bank [NREG];   // register bank driven by DUT pulses
  logic [DW-1:0] mdl  [NREG];   // expected register contents
  logic          mprio;         // expected round-robin pointer

  regbank_access_arb #(.NREG(NREG), .DW(DW), .AW(AW), .RO_MASK(RO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .we_i(we_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
    .rdata_o(rdata_o), .err_o(err_o), .reg_we_o(reg_we_o), .reg_re_o(reg_re_o),
    .reg_wd_o(reg_wd_o), .reg_qs_i(reg_qs_i)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [DW-1:0] init_val(input int i);
    return 32'hA5A5_0000 | 32'(i);
  endfunction

  // Simple register bank: writes on we pulse, slice RC_REG clears on read pulse.
  always @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < NREG; i++) bank[i] <= init_val(i);
    end else begin
      for (int i = 0; i < NREG; i++) if (reg_we_o[i]) bank[i] <= reg_wd_o;
      if (reg_re_o[RC_REG]) bank[RC_REG] <= '0;
    end
  end

  for (genvar gi = 0; gi < NREG; gi++) begin : g_qs
    assign reg_qs_i[gi*DW +: DW] = bank[gi];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mdl_reset();
    for (int i = 0; i < NREG; i++) mdl[i] = init_val(i);
    mprio = 1'b0;
  endtask

  // One complete transaction starting in an IDLE cycle; returns in the next IDLE cycle.
  task automatic txn(input logic [1:0] req, input logic [1:0] we,
                     input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                     input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    logic          win, w, e;
    logic [AW-1:0] a;
    logic [DW-1:0] d, rd;
    logic [NREG-1:0] oh;
    req_i = req; we_i = we; addr_i = {a1, a0}; wdata_i = {d1, d0};
    win   = (req == 2'b11) ? mprio : req[1];
    mprio = ~win;
    w  = we[win];
    a  = win ? a1 : a0;
    d  = win ? d1 : d0;
    e  = (int'(a) >= NREG) ? 1'b1 : (w && RO[a]);
    oh = e ? '0 : (NREG'(1) << a);
    rd = (!w && !e) ? mdl[a] : '0;
    $display("txn req=%b win=%0d %s addr=%0d wdata=%h err=%0d rdata=%h",
             req, win, w ? "WR" : "RD", a, d, e, rd);
    // cycle T: grant
    @(negedge clk_i);
    chk("gnt_T", gnt_o, 2'b01 << win);
    chk("onehot_gnt", 64'($countones(gnt_o) <= 1), 64'd1);
    chk("rvalid_T", rvalid_o, 2'b00);
    // cycle T+1: slice pulse
    @(posedge clk_i); #1;
    @(negedge clk_i);
    chk("gnt_T1", gnt_o, 2'b00);
    chk("reg_we_T1", reg_we_o, (w ? oh : '0));
    chk("reg_re_T1", reg_re_o, (w ? '0 : oh));
    if (w && !e) chk("reg_wd_T1", reg_wd_o, d);
    chk("rvalid_T1", rvalid_o, 2'b00);
    chk("rdata_idle", rdata_o, '0);
    // cycle T+2: response
    @(posedge clk_i); #1;
    @(negedge clk_i);
    chk("gnt_T2", gnt_o, 2'b00);
    chk("pulse_T2", {reg_we_o, reg_re_o}, '0);
    chk("rvalid_T2", rvalid_o, 2'b01 << win);
    chk("err_T2", err_o, e);
    chk("rdata_T2", rdata_o, rd);
    if (!e && w) mdl[a] = d;
    if (!e && !w && int'(a) == RC_REG) mdl[RC_REG] = '0;
    @(posedge clk_i); #1;
  endtask

  initial begin
    rst_ni = 1'b0; req_i = '0; we_i = '0; addr_i = '0; wdata_i = '0;
    mdl_reset();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_gnt", gnt_o, 2'b00);
    chk("rst_rvalid", rvalid_o, 2'b00);
    chk("rst_rdata", rdata_o, '0);
    chk("rst_err", err_o, 1'b0);
    chk("rst_reg_we", reg_we_o, '0);
    chk("rst_reg_re", reg_re_o, '0);
    chk("rst_reg_wd", reg_wd_o, '0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;

    // Contention: both requesters held, grant order 0,1,0,1 every 3 cycles.
    for (int k = 0; k < 4; k++)
      txn(2'b11, 2'b11, 3'd0, 3'd1, 32'h1111_0000 + 32'(k), 32'h2222_0000 + 32'(k));

    // Single write from requester 0.
    txn(2'b01, 2'b01, 3'd2, 3'd0, 32'hDEADBEEF, 32'h0);
    chk("bank2", bank[2], 32'hDEADBEEF);

    // Read-to-clear: load 0x1F, then read it back.
    txn(2'b01, 2'b01, 3'd5, 3'd0, 32'h1F, 32'h0);
    txn(2'b01, 2'b00, 3'd5, 3'd0, 32'h0, 32'h0);
    chk("bank5_cleared", bank[5], 32'h0);

    // Errors: unmapped write, read-only write, then a good read.
    txn(2'b01, 2'b01, 3'd7, 3'd0, 32'hCAFE_0007, 32'h0);
    txn(2'b10, 2'b10, 3'd0, 3'd1, 32'h0, 32'hCAFE_0001);
    txn(2'b01, 2'b00, 3'd1, 3'd0, 32'h0, 32'h0);
    chk("bank1_untouched", bank[1], init_val(1));

    // Lone requests from 1, then a simultaneous request goes to 0.
    for (int k = 0; k < 3; k++) txn(2'b10, 2'b00, 3'd0, 3'(k), 32'h0, 32'h0);
    txn(2'b11, 2'b00, 3'd3, 3'd4, 32'h0, 32'h0);

    // Reset during ACCESS of a write.
    req_i = 2'b01; we_i = 2'b01; addr_i = {3'd0, 3'd3}; wdata_i = {32'h0, 32'h1234_5678};
    @(negedge clk_i);
    chk("mid_gnt", gnt_o, 2'b01);
    @(posedge clk_i); #1;
    req_i = 2'b00;
    @(negedge clk_i);
    chk("mid_we_before", reg_we_o, NREG'(8));
    #1 rst_ni = 1'b0;
    #1;
    chk("mid_we_async", reg_we_o, '0);
    chk("mid_rvalid", rvalid_o, 2'b00);
    mdl_reset();
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    repeat (3) begin
      @(negedge clk_i);
      chk("post_rst_quiet", {rvalid_o, reg_we_o, reg_re_o}, '0);
    end
    @(posedge clk_i); #1;
    txn(2'b10, 2'b01, 3'd3, 3'd3, 32'h0, 32'h0BAD_F00D);

    // Random traffic against the model.
    for (int k = 0; k < 24; k++)
      txn(2'($urandom_range(1, 3)), 2'($urandom_range(0, 3)),
          3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), $urandom, $urandom);
    req_i = 2'b00;
    for (int i = 0; i < NREG; i++) chk("bank_final", bank[i], mdl[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
